uart_rx: RTL and testbench

- Serial UART receiver; the counterpart to the team's uart_tx.
- Frame format: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1), no parity. Line idles high.
- Oversamples the input with a per-bit cycle counter and samples each bit at mid-bit.
- Presents each received word with a one-cycle valid strobe to the bus-side logic, e.g. the Wishbone UART wrapper's RX holding register.

---
 rtl/uart_rx.sv | 159 +++++++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : Serial UART receiver. Frame = 1 start bit (0), DATA_BITS data
//             bits LSB first, 1 stop bit (1), no parity; the line idles high.
//             The line is synchronized, timed by a per-bit cycle counter and
//             sampled at mid-bit. Each good word is presented with a
//             one-cycle valid strobe; a stop bit sampled low produces a
//             one-cycle frame-error strobe instead.
//  Ports    : i_clk       system clock, all logic on posedge
//             i_rst       asynchronous active-high reset
//             i_rx        serial line from pin (asynchronous to i_clk)
//             o_data      last correctly framed word, held until next good one
//             o_valid     one-cycle strobe, o_data updated this cycle
//             o_frame_err one-cycle strobe, stop bit sampled as 0
//             o_busy      high whenever the receiver is not idle
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
   parameter int DATA_BITS      = 8,
   parameter int CYCLES_PER_BIT = 108
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_frame_err,
   output logic                 o_busy
);

   // Counter reload values: half a bit to reach mid start bit, then one
   // full bit period between consecutive mid-bit samples.
   localparam logic [7:0] c_half_m1 = 8'(CYCLES_PER_BIT / 2 - 1);
   localparam logic [7:0] c_bit_m1  = 8'(CYCLES_PER_BIT - 1);
   localparam logic [3:0] c_last_ix = 4'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_HIGH = 3'd4
   } state_t;

   state_t               r_state;
   logic                 r_rx_m;
   logic                 r_rx_s;
   logic [7:0]           r_cnt;
   logic [3:0]           r_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 w_tick;

   // Two-flop synchronizer; both flops reset to the idle (high) level so a
   // reset never looks like a start edge.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rx_m <= 1'b1;
         r_rx_s <= 1'b1;
      end else begin
         r_rx_m <= i_rx;
         r_rx_s <= r_rx_m;
      end
   end

   assign w_tick = (r_cnt == 8'd0);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 8'd0;
         r_idx       <= 4'd0;
         r_shift     <= '0;
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         o_valid     <= 1'b0;
         o_frame_err <= 1'b0;

         // Counter runs only while a frame is being timed; on a tick it
         // reloads a full bit period.
         if (r_state == ST_START || r_state == ST_DATA || r_state == ST_STOP) begin
            if (w_tick) begin
               r_cnt <= c_bit_m1;
            end else begin
               r_cnt <= r_cnt - 8'd1;
            end
         end

         case (r_state)
            ST_IDLE: begin
               if (!r_rx_s) begin
                  r_cnt   <= c_half_m1;
                  r_state <= ST_START;
                  o_busy  <= 1'b1;
               end
            end

            ST_START: begin
               if (w_tick) begin
                  if (!r_rx_s) begin
                     r_state <= ST_DATA;
                     r_idx   <= 4'd0;
                  end else begin
                     // Line was high again at mid start bit: a glitch.
                     r_state <= ST_IDLE;
                     o_busy  <= 1'b0;
                  end
               end
            end

            ST_DATA: begin
               if (w_tick) begin
                  // LSB arrives first, so shifting right leaves the word
                  // LSB-aligned after the last sample.
                  r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                  r_idx   <= r_idx + 4'd1;
                  if (r_idx == c_last_ix) begin
                     r_state <= ST_STOP;
                  end
               end
            end

            ST_STOP: begin
               if (w_tick) begin
                  if (r_rx_s) begin
                     // Returning to idle mid stop bit lets an immediately
                     // following start edge be caught.
                     o_data  <= r_shift;
                     o_valid <= 1'b1;
                     r_state <= ST_IDLE;
                     o_busy  <= 1'b0;
                  end else begin
                     o_frame_err <= 1'b1;
                     r_state     <= ST_WAIT_HIGH;
                  end
               end
            end

            ST_WAIT_HIGH: begin
               // A line held low (break) must not be decoded as new frames.
               if (r_rx_s) begin
                  r_state <= ST_IDLE;
                  o_busy  <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. One receiver runs at 16
//             clocks per bit for the directed and random frames, a second at
//             108 clocks per bit is fed by a behavioural transmitter. Sent
//             words go into per-receiver queues; monitors pop and compare on
//             every valid strobe.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

   localparam int CPB    = 16;
   localparam int CPB_LB = 108;
   localparam int N_LB   = 48;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx = 1'b1;
   logic       rx_lb = 1'b1;
   logic [7:0] data, data_lb;
   logic       valid, valid_lb, ferr, ferr_lb, busy, busy_lb;

   int n_total = 0;
   int n_bad   = 0;
   int n_valid = 0, n_valid_lb = 0;
   int n_ferr  = 0, n_ferr_lb  = 0;
   logic prev_valid = 1'b0;
   logic [7:0] q_exp[$];
   logic [7:0] q_lb[$];
   logic [7:0] last_good = 8'h00;

   always #5 clk = ~clk;

   uart_rx #(.DATA_BITS(8), .CYCLES_PER_BIT(CPB)) dut (
      .i_clk(clk), .i_rst(rst), .i_rx(rx),
      .o_data(data), .o_valid(valid), .o_frame_err(ferr), .o_busy(busy)
   );

   uart_rx #(.DATA_BITS(8), .CYCLES_PER_BIT(CPB_LB)) dut_lb (
      .i_clk(clk), .i_rst(rst), .i_rx(rx_lb),
      .o_data(data_lb), .o_valid(valid_lb), .o_frame_err(ferr_lb), .o_busy(busy_lb)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitors: every strobe is judged against the reference queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (valid) begin
            n_valid++;
            chk("strobe_overlap", {31'd0, ferr}, 32'd0);
            chk("valid_width", {31'd0, prev_valid}, 32'd0);
            if (q_exp.size() != 0) begin
               last_good = q_exp.pop_front();
               chk("rx_data", {24'd0, data}, {24'd0, last_good});
            end else begin
               chk("extra_valid", {31'd0, valid}, 32'd0);
            end
         end
         if (ferr) n_ferr++;
         prev_valid = valid;
         if (valid_lb) begin
            n_valid_lb++;
            if (q_lb.size() != 0) begin
               chk("lb_data", {24'd0, data_lb}, {24'd0, q_lb.pop_front()});
            end else begin
               chk("lb_extra_valid", {31'd0, valid_lb}, 32'd0);
            end
         end
         if (ferr_lb) n_ferr_lb++;
      end
   end

   task automatic set_line(input bit lb, input logic v);
      if (lb) rx_lb = v;
      else    rx    = v;
   endtask

   // Behavioural transmitter; called at 1 time unit after a rising edge.
   task automatic send_frame(input logic [7:0] d, input logic stop_v, input int cpb, input bit lb);
      logic [9:0] bits;
      bits = {stop_v, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         set_line(lb, bits[i]);
         repeat (cpb) @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input bit lb, input int budget);
      int c = 0;
      while (((lb ? q_lb.size() : q_exp.size()) != 0) && c < budget) begin
         @(posedge clk);
         c++;
      end
      #1;
      chk(lb ? "lb_drain" : "drain", lb ? q_lb.size() : q_exp.size(), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

   initial begin
      int busy_seen, v0, f0, lat;
      logic [7:0] b;

      // ---- reset and idle line ----
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      busy_seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         if (busy || valid || ferr) busy_seen++;
      end
      chk("reset_data", {24'd0, data}, 32'd0);
      chk("idle_activity", busy_seen, 0);
      chk("idle_valid_cnt", n_valid, 0);
      chk("idle_ferr_cnt", n_ferr, 0);

      // ---- single frame with latency ----
      // Strobe appears 2 (sync) + HALF + 9*CPB = 154 clocks after the first
      // clock edge that sees the pin low.
      q_exp.push_back(8'hA5);
      lat = 0;
      fork
         send_frame(8'hA5, 1'b1, CPB, 1'b0);
         begin
            @(posedge clk);
            #1;
            while (!valid && lat < 400) begin
               @(posedge clk);
               #1;
               lat++;
            end
            chk("a5_latency", lat, 154);
            chk("a5_busy_at_valid", {31'd0, busy}, 32'd0);
            chk("a5_data", {24'd0, data}, 32'h0000_00A5);
         end
      join
      drain(1'b0, 100);
      chk("a5_valid_cnt", n_valid, 1);

      // ---- back-to-back frames ----
      v0 = n_valid; f0 = n_ferr;
      q_exp.push_back(8'h00); q_exp.push_back(8'hFF); q_exp.push_back(8'h3C);
      send_frame(8'h00, 1'b1, CPB, 1'b0);
      send_frame(8'hFF, 1'b1, CPB, 1'b0);
      send_frame(8'h3C, 1'b1, CPB, 1'b0);
      drain(1'b0, 100);
      idle(10);
      chk("b2b_valid_cnt", n_valid - v0, 3);
      chk("b2b_ferr_cnt", n_ferr - f0, 0);

      // ---- short glitch ----
      v0 = n_valid; f0 = n_ferr;
      busy_seen = 0;
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (busy) busy_seen = 1;
      end
      chk("glitch_busy_seen", busy_seen, 1);
      chk("glitch_busy_end", {31'd0, busy}, 32'd0);
      chk("glitch_valid_cnt", n_valid - v0, 0);
      chk("glitch_ferr_cnt", n_ferr - f0, 0);

      // ---- framing error, line held low ----
      v0 = n_valid; f0 = n_ferr;
      send_frame(8'h55, 1'b0, CPB, 1'b0);
      idle(300);
      chk("ferr_cnt", n_ferr - f0, 1);
      chk("ferr_valid_cnt", n_valid - v0, 0);
      chk("ferr_data_held", {24'd0, data}, {24'd0, last_good});
      chk("ferr_busy_low_line", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      idle(20);
      chk("ferr_recover_busy", {31'd0, busy}, 32'd0);
      q_exp.push_back(8'h81);
      send_frame(8'h81, 1'b1, CPB, 1'b0);
      drain(1'b0, 100);
      chk("ferr_total", n_ferr - f0, 1);

      // ---- reset in the middle of data bit 4 ----
      v0 = n_valid; f0 = n_ferr;
      b = 8'h6B;
      rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = b[i];
         idle(CPB);
      end
      rx = b[4];
      idle(CPB / 2);
      rst = 1'b1;
      idle(3);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rx = 1'b1;
      rst = 1'b0;
      idle(CPB * 12);
      chk("abort_valid_cnt", n_valid - v0, 0);
      chk("abort_ferr_cnt", n_ferr - f0, 0);
      q_exp.push_back(8'h7E);
      send_frame(8'h7E, 1'b1, CPB, 1'b0);
      drain(1'b0, 100);
      chk("after_rst_valid_cnt", n_valid - v0, 1);

      // ---- randomized frames with random gaps ----
      v0 = n_valid; f0 = n_ferr;
      for (int i = 0; i < 16; i++) begin
         b = 8'($urandom);
         q_exp.push_back(b);
         send_frame(b, 1'b1, CPB, 1'b0);
         idle($urandom_range(0, 20));
      end
      drain(1'b0, 200);
      chk("rand_valid_cnt", n_valid - v0, 16);
      chk("rand_ferr_cnt", n_ferr - f0, 0);

      // ---- loopback at 108 clocks per bit ----
      for (int i = 0; i < N_LB; i++) begin
         b = 8'($urandom);
         q_lb.push_back(b);
         send_frame(b, 1'b1, CPB_LB, 1'b1);
      end
      drain(1'b1, 400);
      chk("lb_valid_cnt", n_valid_lb, N_LB);
      chk("lb_ferr_cnt", n_ferr_lb, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
